// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write link.
// Used by both the initiator and the register peripheral.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bit 15 is the write flag; every frame on this link is a write.
    function automatic logic [FRAME_W-1:0] mk_frame(
        logic [ADDR_W-1:0] addr,
        logic [DATA_W-1:0] data
    );
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_req_if.sv
// Valid/ready request channel carrying one register write.
// The requester is the master; the SPI initiator is the slave.
interface spi_req_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: serialises {1, addr, data} frames MSB first.
// All pin outputs are registered from the next-state decode.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic     clk,
    input  logic     rst,
    spi_req_if.slave req,
    output logic     busy,
    output logic     done,
    output logic     nCS,
    output logic     SCLK,
    output logic     COPI
);

    localparam int CNT_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DIV_LD   = cnt_t'(CLK_DIV - 1);
    localparam cnt_t SETUP_LD = cnt_t'(CS_SETUP - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(CS_HOLD - 1);
    localparam cnt_t GAP_LD   = cnt_t'(CS_GAP - 1);

    if (CLK_DIV < 3 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 4)
    begin : g_bad_params
        $error("spi_controller: illegal timing parameters");
    end

    spi_state_e         state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               ncs_q, ncs_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    assign accept = req.req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        copi_d  = copi_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    bit_d   = 4'hF;
                    shift_d = mk_frame(req.req_addr, req.req_data);
                    copi_d  = shift_d[FRAME_W-1];
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = DIV_LD;
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = DIV_LD;
                    // COPI moves with the falling edge; after bit 0 it holds.
                    if (bit_q != '0) begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        copi_d  = shift_q[FRAME_W-2];
                    end
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_q == '0) begin
                    if (bit_q == '0) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = ST_SHIFT_HI;
                        cnt_d   = DIV_LD;
                        bit_d   = bit_q - 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ncs_d   = !(state_d inside {ST_SETUP, ST_SHIFT_HI,
                                    ST_SHIFT_LO, ST_HOLD});
        sclk_d  = (state_d == ST_SHIFT_HI);
        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign req.req_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign nCS           = ncs_q;
    assign SCLK          = sclk_q;
    assign COPI          = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench: two initiators (default and D=3/G=4) checked by a
// pin-level peripheral model against frames queued at request time.
module tb_spi_controller;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_req_if req_a ();
    spi_req_if req_b ();

    logic busy_w[2], done_w[2], ncs_w[2], sclk_w[2], copi_w[2];

    spi_controller u_dut_a (
        .clk (clk), .rst (rst), .req (req_a),
        .busy(busy_w[0]), .done(done_w[0]), .nCS(ncs_w[0]),
        .SCLK(sclk_w[0]), .COPI(copi_w[0])
    );

    spi_controller #(.CLK_DIV(3), .CS_GAP(4)) u_dut_b (
        .clk (clk), .rst (rst), .req (req_b),
        .busy(busy_w[1]), .done(done_w[1]), .nCS(ncs_w[1]),
        .SCLK(sclk_w[1]), .COPI(copi_w[1])
    );

    typedef struct {
        logic [15:0] f;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  pregs[2][8];
    logic [15:0] shv[2];
    int   hi_run[2], lo_run[2], low_len[2], rises[2];
    int   last_acc[2], last_done[2];
    bit   in_frame[2], wait_ready[2];
    logic p_ncs[2], p_sclk[2], p_copi[2], p_rdy[2];

    // Timing of each instance, straight from its parameters.
    function automatic int p_d(int m); return (m == 0) ? 4 : 3; endfunction
    function automatic int p_s(int m); return 4; endfunction
    function automatic int p_h(int m); return 4; endfunction
    function automatic int p_g(int m); return (m == 0) ? 8 : 4; endfunction
    function automatic int t_done(int m);
        return 1 + p_s(m) + 32 * p_d(m) + p_h(m);
    endfunction
    function automatic int t_rdy(int m);
        return t_done(m) + p_g(m);
    endfunction

    function automatic void chk(int m, string name,
                                logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d) at cycle %0d: got %0h, expected %0h",
                     name, m, cyc, act, exp);
        end
    endfunction

    function automatic logic rdy(int m);
        return (m == 0) ? req_a.req_ready : req_b.req_ready;
    endfunction

    function automatic int q_size(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void q_push(int m, exp_t e);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic exp_t q_pop(int m);
        return (m == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void q_drop_last(int m);
        if (m == 0) void'(q0.pop_back());
        else        void'(q1.pop_back());
    endfunction

    task automatic set_valid(int m, logic v);
        if (m == 0) req_a.req_valid = v;
        else        req_b.req_valid = v;
    endtask

    task automatic set_req(int m, logic [6:0] a, logic [7:0] d);
        if (m == 0) begin
            req_a.req_addr = a;
            req_a.req_data = d;
        end else begin
            req_b.req_addr = a;
            req_b.req_data = d;
        end
    endtask

    // Peripheral model: samples COPI on SCLK rises, commits at nCS rise.
    task automatic mon_step(int m);
        logic ncs, sclk, copi, dn, bsy, rd;
        exp_t e;
        ncs  = ncs_w[m];
        sclk = sclk_w[m];
        copi = copi_w[m];
        dn   = done_w[m];
        bsy  = busy_w[m];
        rd   = rdy(m);
        if (rst) begin
            chk(m, "reset_ncs", ncs, 1);
            chk(m, "reset_sclk", sclk, 0);
            chk(m, "reset_copi", copi, 0);
            chk(m, "reset_done", dn, 0);
            chk(m, "reset_busy", bsy, 0);
            chk(m, "reset_ready", rd, 0);
            in_frame[m]   = 0;
            wait_ready[m] = 0;
            rises[m]      = 0;
        end else begin
            chk(m, "busy_vs_ready", bsy, !rd);
            if (!ncs && p_ncs[m]) begin
                in_frame[m] = 1;
                rises[m]    = 0;
                low_len[m]  = 0;
                lo_run[m]   = 0;
                hi_run[m]   = 0;
                chk(m, "copi_write_flag", copi, 1);
            end
            if (sclk && !p_sclk[m]) begin
                chk(m, "sclk_rise_ncs_low", ncs, 0);
                rises[m]++;
                shv[m] = {shv[m][14:0], copi};
                if (rises[m] == 1)
                    chk(m, "setup_cycles", low_len[m], p_s(m));
                else
                    chk(m, "sclk_low_phase", lo_run[m], p_d(m));
                hi_run[m] = 0;
            end
            if (!sclk && p_sclk[m]) begin
                chk(m, "sclk_high_phase", hi_run[m], p_d(m));
                lo_run[m] = 0;
            end
            if (!ncs && !p_ncs[m] && copi !== p_copi[m])
                chk(m, "copi_moves_on_fall", !sclk && p_sclk[m], 1);
            if (dn && !(ncs && !p_ncs[m] && in_frame[m]))
                chk(m, "stray_done", dn, 0);
            if (ncs && !p_ncs[m] && in_frame[m]) begin
                in_frame[m] = 0;
                chk(m, "done_at_ncs_rise", dn, 1);
                chk(m, "sclk_rise_count", rises[m], 16);
                chk(m, "ncs_low_cycles", low_len[m], t_done(m) - 1);
                if (q_size(m) == 0) begin
                    chk(m, "unexpected_frame", shv[m], 0);
                end else begin
                    e = q_pop(m);
                    chk(m, "frame_bits", shv[m], e.f);
                    chk(m, "done_latency", cyc - e.acc, t_done(m));
                    last_acc[m]   = e.acc;
                    last_done[m]  = cyc;
                    wait_ready[m] = 1;
                end
                if (shv[m][15] && shv[m][14:8] < 7'd8)
                    pregs[m][shv[m][10:8]] = shv[m][7:0];
            end
            if (rd && !p_rdy[m] && wait_ready[m]) begin
                chk(m, "ready_latency", cyc - last_acc[m], t_rdy(m));
                wait_ready[m] = 0;
            end
            if (!ncs) low_len[m]++;
            if (sclk) hi_run[m]++;
            else      lo_run[m]++;
        end
        p_ncs[m]  = ncs;
        p_sclk[m] = sclk;
        p_copi[m] = copi;
        p_rdy[m]  = rd;
    endtask

    task automatic send(int m, logic [6:0] a, logic [7:0] d,
                        bit hold, bit chg, bit b2b, output int acc);
        int   w;
        exp_t e;
        @(negedge clk);
        set_req(m, a, d);
        set_valid(m, 1'b1);
        w = 0;
        while (!rdy(m) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (!rdy(m)) begin
            chk(m, "accept_timeout", 0, 1);
            set_valid(m, 1'b0);
            return;
        end
        e.f   = mk_frame(a, d);
        e.acc = cyc;
        q_push(m, e);
        if (b2b) chk(m, "b2b_gap_cycles", cyc - last_done[m], p_g(m));
        @(negedge clk);
        if (chg) set_req(m, a, d ^ 8'hFF);
        if (!hold) set_valid(m, 1'b0);
    endtask

    task automatic wait_idle(int m);
        int w;
        w = 0;
        while ((q_size(m) != 0 || !rdy(m) || wait_ready[m]) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) chk(m, "idle_timeout", 0, 1);
    endtask

    int acc;
    int w;

    initial begin
        req_a.req_valid = 1'b0;
        req_b.req_valid = 1'b0;
        set_req(0, '0, '0);
        set_req(1, '0, '0);
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 8; r++) pregs[m][r] = 8'h00;
            p_ncs[m] = 1; p_sclk[m] = 0; p_copi[m] = 0; p_rdy[m] = 0;
            in_frame[m] = 0; wait_ready[m] = 0; shv[m] = '0;
        end
        #1 rst = 1'b1;

        fork
            forever begin
                @(negedge clk);
                mon_step(0);
                mon_step(1);
            end
        join_none

        repeat (5) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk(0, "ready_after_reset", rdy(0), 1);
        chk(1, "ready_after_reset", rdy(1), 1);

        send(0, ADDR_PWM_DUTY, 8'hA5, 0, 0, 0, acc);
        wait_idle(0);
        chk(0, "reg_pwm_duty", pregs[0][4], 8'hA5);

        // GAP cycles then the accept cycle keep nCS high between frames.
        send(0, ADDR_EN_OUT_7_0, 8'hFF, 1, 0, 0, acc);
        send(0, ADDR_EN_OUT_15_8, 8'h0F, 0, 0, 1, acc);
        wait_idle(0);
        chk(0, "reg_en_out_lo", pregs[0][0], 8'hFF);
        chk(0, "reg_en_out_hi", pregs[0][1], 8'h0F);

        send(1, ADDR_EN_PWM_7_0, 8'h55, 0, 0, 0, acc);
        wait_idle(1);
        chk(1, "reg_en_pwm_lo", pregs[1][2], 8'h55);

        send(0, ADDR_EN_PWM_15_8, 8'h3C, 0, 1, 0, acc);
        wait_idle(0);
        chk(0, "reg_captured_on_accept", pregs[0][3], 8'h3C);

        // Abort inside the high phase of bit 7.
        send(0, ADDR_PWM_DUTY, 8'h11, 0, 0, 0, acc);
        w = 0;
        while (cyc < acc + 1 + p_s(0) + 16 * p_d(0) + 1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk(0, "abort_in_high_phase", sclk_w[0], 1);
        q_drop_last(0);
        #3 rst = 1'b1;
        #1;
        chk(0, "async_reset_ncs", ncs_w[0], 1);
        chk(0, "async_reset_sclk", sclk_w[0], 0);
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk(0, "ready_after_abort", rdy(0), 1);
        chk(0, "partial_frame_dropped", pregs[0][4], 8'hA5);
        send(0, ADDR_PWM_DUTY, 8'h66, 0, 0, 0, acc);
        wait_idle(0);
        chk(0, "reg_after_abort", pregs[0][4], 8'h66);

        for (int i = 0; i < 10; i++) begin
            int m;
            m = int'($urandom_range(0, 1));
            send(m, 7'($urandom), 8'($urandom), 0, 0, 0, acc);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
